// File: rtl/ct_pkt_arb.sv
// ct_pkt_arb -- packet-locked round-robin arbiter for NI requesters onto one
// shared sink (e.g. a clock-crossing FIFO write port). It stores no data.
// Once a requester wins, it keeps the grant until its end-of-packet beat
// transfers. Every packet is preceded by one IDLE arbitration cycle.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   i_data   requester data; requester k sits at [k*WIDTH +: WIDTH]
//   i_valid  per-requester beat valid
//   i_eop    per-requester end-of-packet (qualified by i_valid)
//   o_ready  per-requester ready (only the granted bit can be set)
//   o_data   arbitrated data to the sink
//   o_valid  arbitrated valid
//   o_eop    arbitrated end-of-packet
//   i_ready  sink ready
//   o_grant  one-hot current grant; zero while idle

// Per-requester slice. The slice passes its requester's beat through when it
// is selected and drives zeros otherwise, so the top can OR all slices
// together without a wide mux.
module ct_pkt_arb_lane #(
  parameter int WIDTH = 1
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  input  logic             eop,
  input  logic             sink_ready,
  output logic             ready,
  output logic [WIDTH-1:0] data_g,
  output logic             valid_g,
  output logic             eop_g
);
  assign ready   = sel & sink_ready;
  assign data_g  = sel ? data : '0;
  assign valid_g = sel & valid;
  assign eop_g   = sel & eop;
endmodule

module ct_pkt_arb #(
  parameter int WIDTH = 1,
  parameter int NI    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NI*WIDTH-1:0] i_data,
  input  logic [NI-1:0]       i_valid,
  input  logic [NI-1:0]       i_eop,
  output logic [NI-1:0]       o_ready,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_valid,
  output logic                o_eop,
  input  logic                i_ready,
  output logic [NI-1:0]       o_grant
);
  localparam int PW = (NI > 1) ? $clog2(NI) : 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        state, state_n;
  logic [PW-1:0] ptr, ptr_n;     // last requester to finish a packet
  logic [PW-1:0] gidx, gidx_n;   // granted requester while LOCKED

  logic          win_any;
  logic [PW-1:0] win_idx, cand;

  logic [NI-1:0][WIDTH-1:0] lane_data;
  logic [NI-1:0]            lane_valid, lane_eop, lane_sel;
  logic                     xfer;

  // Round-robin search from ptr+1 upward. The modulo is done in int so the
  // index never leaves 0..NI-1, even for non-power-of-2 NI.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NI; off++) begin
      cand = PW'((int'(ptr) + off) % NI);
      if (!win_any && i_valid[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign o_grant  = (state == LOCKED) ? (NI'(1) << gidx) : '0;
  // Reset gates the lanes so valid/ready are quiet while reset is held,
  // even though the registered grant only clears at the edge.
  assign lane_sel = o_grant & {NI{~reset}};

  for (genvar k = 0; k < NI; k++) begin : g_lane
    ct_pkt_arb_lane #(.WIDTH(WIDTH)) u_lane (
      .sel        (lane_sel[k]),
      .data       (i_data[k*WIDTH +: WIDTH]),
      .valid      (i_valid[k]),
      .eop        (i_eop[k]),
      .sink_ready (i_ready),
      .ready      (o_ready[k]),
      .data_g     (lane_data[k]),
      .valid_g    (lane_valid[k]),
      .eop_g      (lane_eop[k])
    );
  end

  always_comb begin
    o_data  = '0;
    o_valid = 1'b0;
    o_eop   = 1'b0;
    for (int k = 0; k < NI; k++) begin
      o_data  = o_data | lane_data[k];
      o_valid = o_valid | lane_valid[k];
      o_eop   = o_eop | lane_eop[k];
    end
  end

  assign xfer = o_valid & i_ready;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gidx_n  = gidx;
    case (state)
      IDLE: begin
        if (win_any) begin
          state_n = LOCKED;
          gidx_n  = win_idx;
        end
      end
      LOCKED: begin
        // Lock holds through valid gaps; only a transferred eop releases it.
        if (xfer && o_eop) begin
          state_n = IDLE;
          ptr_n   = gidx;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= PW'(NI - 1);   // requester 0 searched first
      gidx  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gidx  <= gidx_n;
    end
  end
endmodule

// File: tb/tb_ct_pkt_arb.sv
module tb_ct_pkt_arb;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // NI=2 instance
  logic [2*W-1:0] a_data;
  logic [1:0]     a_valid, a_eop, a_oready, a_grant;
  logic           a_iready, a_ovalid, a_oeop;
  logic [W-1:0]   a_odata;

  // NI=3 instance
  logic [3*W-1:0] b_data;
  logic [2:0]     b_valid, b_eop, b_oready, b_grant;
  logic           b_iready, b_ovalid, b_oeop;
  logic [W-1:0]   b_odata;

  ct_pkt_arb #(.WIDTH(W), .NI(2)) dut2 (
    .clk(clk), .reset(reset), .i_data(a_data), .i_valid(a_valid), .i_eop(a_eop),
    .o_ready(a_oready), .o_data(a_odata), .o_valid(a_ovalid), .o_eop(a_oeop),
    .i_ready(a_iready), .o_grant(a_grant));

  ct_pkt_arb #(.WIDTH(W), .NI(3)) dut3 (
    .clk(clk), .reset(reset), .i_data(b_data), .i_valid(b_valid), .i_eop(b_eop),
    .o_ready(b_oready), .o_data(b_odata), .o_valid(b_ovalid), .o_eop(b_oeop),
    .i_ready(b_iready), .o_grant(b_grant));

  typedef struct {
    logic       rst;
    logic [1:0] v, e;
    logic [7:0] d0, d1;
    logic       rdy;
    logic       chk;
    logic [1:0] g;
    logic       ov;
    logic [1:0] ordy;
    logic [7:0] od;
    logic       oe;
  } vec_t;

  localparam int NV = 28;
  vec_t tv[NV];
  int checks = 0, errors = 0;

  function automatic vec_t mk(logic rst, logic [1:0] v, logic [1:0] e, logic [7:0] d0,
                              logic [7:0] d1, logic rdy, logic chk, logic [1:0] g, logic ov,
                              logic [1:0] ordy, logic [7:0] od, logic oe);
    vec_t t;
    t.rst = rst; t.v = v; t.e = e; t.d0 = d0; t.d1 = d1; t.rdy = rdy; t.chk = chk;
    t.g = g; t.ov = ov; t.ordy = ordy; t.od = od; t.oe = oe;
    return t;
  endfunction

  task automatic cmp3(input string nm, input logic [2:0] g, input logic ov,
                      input logic [2:0] r, input logic [7:0] d, input logic oe);
    checks++;
    if (b_grant !== g || b_ovalid !== ov || b_oready !== r || b_odata !== d || b_oeop !== oe) begin
      errors++;
      $display("FAIL %s got g=%b v=%b r=%b d=%h e=%b want g=%b v=%b r=%b d=%h e=%b",
               nm, b_grant, b_ovalid, b_oready, b_odata, b_oeop, g, ov, r, d, oe);
    end
  endtask

  initial begin
    // rst v    e    d0     d1     rdy chk  g    ov  ordy  od     oe
    // reset
    tv[0]  = mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[1]  = mk(1, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    // both single-beat: grant 00,01,00,10
    tv[2]  = mk(0, 2'b11, 2'b11, 8'hA1, 8'hB1, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[3]  = mk(0, 2'b11, 2'b11, 8'hA1, 8'hB1, 1, 1, 2'b01, 1, 2'b01, 8'hA1, 1);
    tv[4]  = mk(0, 2'b11, 2'b11, 8'hA1, 8'hB1, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[5]  = mk(0, 2'b11, 2'b11, 8'hA1, 8'hB1, 1, 1, 2'b10, 1, 2'b10, 8'hB1, 1);
    tv[6]  = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    // req1 3-beat, req0 joins on beat 2
    tv[7]  = mk(0, 2'b10, 2'b00, 8'hA2, 8'hC1, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[8]  = mk(0, 2'b10, 2'b00, 8'hA2, 8'hC1, 1, 1, 2'b10, 1, 2'b10, 8'hC1, 0);
    tv[9]  = mk(0, 2'b11, 2'b01, 8'hA2, 8'hC2, 1, 1, 2'b10, 1, 2'b10, 8'hC2, 0);
    tv[10] = mk(0, 2'b11, 2'b11, 8'hA2, 8'hC3, 1, 1, 2'b10, 1, 2'b10, 8'hC3, 1);
    tv[11] = mk(0, 2'b01, 2'b01, 8'hA2, 8'h00, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[12] = mk(0, 2'b01, 2'b01, 8'hA2, 8'h00, 1, 1, 2'b01, 1, 2'b01, 8'hA2, 1);
    // req0 locked, drops valid 4 cycles while req1 waits
    tv[13] = mk(0, 2'b01, 2'b00, 8'hD1, 8'h00, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[14] = mk(0, 2'b01, 2'b00, 8'hD1, 8'h00, 1, 1, 2'b01, 1, 2'b01, 8'hD1, 0);
    tv[15] = mk(0, 2'b10, 2'b10, 8'hD2, 8'hE1, 1, 1, 2'b01, 0, 2'b01, 8'hD2, 0);
    tv[16] = mk(0, 2'b10, 2'b10, 8'hD2, 8'hE1, 1, 1, 2'b01, 0, 2'b01, 8'hD2, 0);
    tv[17] = mk(0, 2'b10, 2'b10, 8'hD2, 8'hE1, 1, 1, 2'b01, 0, 2'b01, 8'hD2, 0);
    tv[18] = mk(0, 2'b10, 2'b10, 8'hD2, 8'hE1, 1, 1, 2'b01, 0, 2'b01, 8'hD2, 0);
    tv[19] = mk(0, 2'b11, 2'b11, 8'hD2, 8'hE1, 1, 1, 2'b01, 1, 2'b01, 8'hD2, 1);
    // sink stalls 5 cycles on a locked beat
    tv[20] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 0, 1, 2'b00, 0, 2'b00, 8'h00, 0);
    tv[21] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 0, 1, 2'b10, 1, 2'b00, 8'hF1, 1);
    tv[22] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 0, 1, 2'b10, 1, 2'b00, 8'hF1, 1);
    tv[23] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 0, 1, 2'b10, 1, 2'b00, 8'hF1, 1);
    tv[24] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 0, 1, 2'b10, 1, 2'b00, 8'hF1, 1);
    tv[25] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 0, 1, 2'b10, 1, 2'b00, 8'hF1, 1);
    tv[26] = mk(0, 2'b10, 2'b10, 8'h00, 8'hF1, 1, 1, 2'b10, 1, 2'b10, 8'hF1, 1);
    tv[27] = mk(0, 2'b00, 2'b00, 8'h00, 8'h00, 1, 1, 2'b00, 0, 2'b00, 8'h00, 0);

    b_data = '0; b_valid = '0; b_eop = '0; b_iready = 1'b1;

    for (int i = 0; i < NV; i++) begin
      reset = tv[i].rst; a_valid = tv[i].v; a_eop = tv[i].e;
      a_data = {tv[i].d1, tv[i].d0}; a_iready = tv[i].rdy;
      @(negedge clk);
      if (tv[i].chk) begin
        checks++;
        if (a_grant !== tv[i].g || a_ovalid !== tv[i].ov || a_oready !== tv[i].ordy ||
            a_odata !== tv[i].od || a_oeop !== tv[i].oe) begin
          errors++;
          $display("FAIL vec%0d got g=%b v=%b r=%b d=%h e=%b want g=%b v=%b r=%b d=%h e=%b",
                   i, a_grant, a_ovalid, a_oready, a_odata, a_oeop,
                   tv[i].g, tv[i].ov, tv[i].ordy, tv[i].od, tv[i].oe);
        end
      end
      @(posedge clk); #1;
    end

    // NI=3: all continuously valid, 1-beat packets -> 0,1,2,0 with ptr wrap
    a_valid = '0; a_eop = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    b_valid = 3'b111; b_eop = 3'b111; b_iready = 1'b1;
    b_data = {8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] eg;
      logic [7:0] ed;
      @(negedge clk);
      if (i % 2 == 0) cmp3($sformatf("rr_idle%0d", i), 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
      else begin
        eg = 3'b001 << ((i / 2) % 3);
        ed = 8'h10 + 8'((i / 2) % 3);
        cmp3($sformatf("rr_grant%0d", i), eg, 1'b1, eg, ed, 1'b1);
      end
      @(posedge clk); #1;
    end

    // req2 4-beat packet, reset on beat 2
    b_valid = 3'b100; b_eop = 3'b000; b_data = {8'h20, 8'h00, 8'h00};
    @(negedge clk); cmp3("r2_idle", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); cmp3("r2_beat1", 3'b100, 1'b1, 3'b100, 8'h20, 1'b0);
    @(posedge clk); #1;
    b_data = {8'h21, 8'h00, 8'h00}; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (b_ovalid !== 1'b0 || b_oready !== 3'b000) begin
      errors++;
      $display("FAIL rst_quiet got v=%b r=%b want v=0 r=000", b_ovalid, b_oready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    b_valid = 3'b111; b_eop = 3'b111; b_data = {8'h22, 8'h31, 8'h30};
    @(negedge clk); cmp3("post_rst", 3'b000, 1'b0, 3'b000, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(negedge clk); cmp3("post_rst_req0", 3'b001, 1'b1, 3'b001, 8'h30, 1'b1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_pkt_arb.md
CT_PKT_ARB -- requirements
Module: ct_pkt_arb

Interface
REQ-001 The parameter list SHALL be: WIDTH, default 1, data bits per beat.
REQ-002 The parameter list SHALL be: NI, default 2, number of requesters; legal range 2..8.
REQ-003 The port list SHALL be: clk  input  1  single clock; all logic on its rising edge.
REQ-004 The port list SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 The port list SHALL be: i_data  input  NI*WIDTH  requester data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-006 The port list SHALL be: i_valid  input  NI  per-requester beat valid.
REQ-007 The port list SHALL be: i_eop  input  NI  per-requester end-of-packet, qualified by i_valid.
REQ-008 The port list SHALL be: o_ready  output  NI  per-requester ready.
REQ-009 The port list SHALL be: o_data  output  WIDTH  arbitrated data to the shared sink (e.g. clock-crossing FIFO write port).
REQ-010 The port list SHALL be: o_valid  output  1  arbitrated valid.
REQ-011 The port list SHALL be: o_eop  output  1  arbitrated end-of-packet.
REQ-012 The port list SHALL be: i_ready  input  1  sink ready.
REQ-013 The port list SHALL be: o_grant  output  NI  one-hot current grant; all-zero when idle.

Function
REQ-014 A beat SHALL transfer on a requester or sink port only in a cycle where valid and ready are both 1.
REQ-015 The FSM SHALL have two states, IDLE and LOCKED, held in registers.
REQ-016 In IDLE: o_grant, o_ready and o_valid SHALL all be 0, and no beat SHALL transfer.
REQ-017 In IDLE with any i_valid bit 1: the winner SHALL be the first set bit searched from index ptr+1 upward, wrapping modulo NI.
REQ-018 On that IDLE cycle, next cycle SHALL be LOCKED with o_grant one-hot at the winner.
REQ-019 In IDLE with i_valid all 0: state SHALL remain IDLE.
REQ-020 In LOCKED with grant g: o_data, o_valid and o_eop SHALL equal i_data[g], i_valid[g] and i_eop[g] combinationally.
REQ-021 In LOCKED with grant g: o_ready[g] SHALL equal i_ready, and all other o_ready bits SHALL be 0.
REQ-022 In LOCKED, the lock SHALL hold while i_valid[g] is 0 mid-packet; no re-arbitration until eop.
REQ-023 A transferred beat with i_eop[g]=1 SHALL set ptr to g, clear o_grant and return to IDLE next cycle.
REQ-024 A single-beat packet (eop on first beat) SHALL take one LOCKED cycle when i_ready=1.
REQ-025 Minimum packet spacing SHALL be one IDLE cycle per packet, so per-packet latency from first valid to first transfer is 1 cycle.
REQ-026 ptr SHALL be ceil(log2(NI)) bits wide and SHALL wrap modulo NI, with no out-of-range value for non-power-of-2 NI.
REQ-027 Non-granted requesters SHALL see o_ready=0 and SHALL hold their beat; the block SHALL store no data.
REQ-028 o_valid SHALL never be 1 in a cycle where o_grant is 0.
REQ-029 o_grant SHALL never have more than one bit set.

Reset
REQ-030 On reset=1 at a clk edge: state SHALL become IDLE, o_grant SHALL become 0, and ptr SHALL become NI-1, so requester 0 has first priority.
REQ-031 While reset=1, o_valid and o_ready SHALL be 0.
REQ-032 Reset mid-packet SHALL abandon the packet without completion; downstream framing recovery is the sink's responsibility.

Verification
REQ-033 The bench SHALL cover: after reset, i_valid=2'b11 both single-beat, i_ready=1 -> req0 granted first and transfers, then IDLE, then req1 transfers; o_grant sequence 00,01,00,10.
REQ-034 The bench SHALL cover: NI=2, req1 sends 3-beat packet while req0 asserts valid from beat 2 -> req0 o_ready=0 until req1 eop transfers; req0 granted two cycles after req1 eop.
REQ-035 The bench SHALL cover: granted req0 drops i_valid for 4 cycles mid-packet while req1 valid -> o_grant stays 01 throughout; no req1 transfer.
REQ-036 The bench SHALL cover: i_ready=0 for 5 cycles during a LOCKED beat -> o_valid=1, o_data stable, o_ready[g]=0; the beat transfers on the first cycle i_ready=1.
REQ-037 The bench SHALL cover: NI=3, all requesters continuously valid with 1-beat packets -> grants 0,1,2,0,... with wrap of ptr from 2 to 0.
REQ-038 The bench SHALL cover: reset asserted on beat 2 of a 4-beat packet from req2 -> next cycle o_grant=0 and o_valid=0, and the next arbitration favours req0.
